// File: rtl/pricing_pkg.sv
// Shared pricing-datapath definitions: regression sequencer states and the
// sample/job widths that the XTX/XTY accumulators also use.
package pricing_pkg;

  localparam int REGSEQ_XW = 3;
  localparam int REGSEQ_YW = 3;
  localparam int JOB_LEN_W = 8;

  typedef enum logic [2:0] {
    RS_IDLE   = 3'd0,
    RS_CLEAR  = 3'd1,
    RS_STREAM = 3'd2,
    RS_DRAIN  = 3'd3,
    RS_DONE   = 3'd4
  } regseq_state_t;

endpackage

// File: rtl/regression_seq_sq_unit.sv
// Combinational unsigned square, W bits in, 2*W bits out (never truncates).
module sq_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0]   a,
  output logic [2*W-1:0] sq
);

  logic [2*W-1:0] a_ext;

  assign a_ext = {{W{1'b0}}, a};
  assign sq    = a_ext * a_ext;

endmodule

// File: rtl/regression_seq.sv
// Least-squares accumulator sequencer: clear, stream samples, drain, pulse done.
// Optional stall timeout in STREAM is enabled by defining REGSEQ_TIMEOUT_EN.
module regression_seq
  import pricing_pkg::*;
#(
  parameter int XW          = REGSEQ_XW,
  parameter int YW          = REGSEQ_YW,
  parameter int ACC_LAT     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_start,
  input  logic [JOB_LEN_W-1:0] job_len,
  input  logic                 smp_valid,
  output logic                 smp_ready,
  input  logic [XW-1:0]        smp_x,
  input  logic [YW-1:0]        smp_y,
  output logic                 acc_clr,
  output logic                 acc_start,
  output logic [XW-1:0]        acc_xi,
  output logic [2*XW-1:0]      acc_xi2,
  output logic [YW-1:0]        acc_yi,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int DW = $clog2(ACC_LAT + 1);

  if (ACC_LAT < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("regression_seq: ACC_LAT and TIMEOUT_CYC must be >= 1");
  end

  regseq_state_t        state;
  logic [JOB_LEN_W-1:0] len_q;
  logic [JOB_LEN_W-1:0] smp_cnt;
  logic [DW-1:0]        drain_cnt;
  logic                 xfer;
  logic                 timeout;
  logic [2*XW-1:0]      sq;

  assign smp_ready = (state == RS_STREAM);
  assign xfer      = smp_valid && smp_ready;
  assign acc_clr   = (state == RS_CLEAR);
  assign busy      = (state != RS_IDLE);
  assign done      = (state == RS_DONE);

  sq_unit #(.W(XW)) u_sq (
    .a  (smp_x),
    .sq (sq)
  );

`ifdef REGSEQ_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  logic [SW-1:0] stall_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle STREAM cycle.
  assign timeout = (state == RS_STREAM) && !smp_valid &&
                   (stall_cnt == SW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt <= '0;
    else if (state != RS_STREAM || smp_valid) stall_cnt <= '0;
    else                                     stall_cnt <= stall_cnt + SW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RS_IDLE;
      len_q     <= '0;
      smp_cnt   <= '0;
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        RS_IDLE: begin
          if (job_start) begin
            if (job_len == '0) begin
              err <= 1'b1;
            end else begin
              len_q   <= job_len;
              smp_cnt <= '0;
              state   <= RS_CLEAR;
            end
          end
        end
        RS_CLEAR: state <= RS_STREAM;
        RS_STREAM: begin
          if (xfer) begin
            smp_cnt <= smp_cnt + JOB_LEN_W'(1);
            if (smp_cnt + JOB_LEN_W'(1) == len_q) begin
              drain_cnt <= '0;
              state     <= RS_DRAIN;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= RS_IDLE;
          end
        end
        // The final beat is registered, so drain spans that beat plus ACC_LAT.
        RS_DRAIN: begin
          if (drain_cnt == DW'(ACC_LAT)) state <= RS_DONE;
          else                           drain_cnt <= drain_cnt + DW'(1);
        end
        RS_DONE: state <= RS_IDLE;
        default: state <= RS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_start <= 1'b0;
      acc_xi    <= '0;
      acc_xi2   <= '0;
      acc_yi    <= '0;
    end else begin
      acc_start <= xfer;
      if (xfer) begin
        acc_xi  <= smp_x;
        acc_xi2 <= sq;
        acc_yi  <= smp_y;
      end
    end
  end

endmodule

// File: tb/tb_regression_seq.sv
// Scoreboard bench for regression_seq: stimulus queues expected beats/done/err
// with their cycle numbers, a negedge monitor pops and compares.
module tb_regression_seq;
  import pricing_pkg::*;

  localparam int XW          = 3;
  localparam int YW          = 3;
  localparam int ACC_LAT     = 2;
  localparam int TIMEOUT_CYC = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            job_start = 1'b0;
  logic [7:0]      job_len = '0;
  logic            smp_valid = 1'b0;
  logic            smp_ready;
  logic [XW-1:0]   smp_x = '0;
  logic [YW-1:0]   smp_y = '0;
  logic            acc_clr, acc_start, busy, done, err;
  logic [XW-1:0]   acc_xi;
  logic [2*XW-1:0] acc_xi2;
  logic [YW-1:0]   acc_yi;

  regression_seq #(.XW(XW), .YW(YW), .ACC_LAT(ACC_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_len(job_len),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_x(smp_x), .smp_y(smp_y),
    .acc_clr(acc_clr), .acc_start(acc_start), .acc_xi(acc_xi), .acc_xi2(acc_xi2),
    .acc_yi(acc_yi), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int xi2;
    int y;
    int at;
  } beat_t;

  beat_t beat_q[$];
  int    done_q[$];
  int    err_q[$];
  int    clr_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every visible output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_start) begin
        chk("beat_expected", int'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_xi", int'(acc_xi), b.x);
          chk("beat_xi2", int'(acc_xi2), b.xi2);
          chk("beat_yi", int'(acc_yi), b.y);
          chk("beat_cycle", cyc, b.at);
        end
      end
      if (done) begin
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) chk("done_cycle", cyc, done_q.pop_front());
      end
      if (err) begin
        chk("err_expected", int'(err_q.size() != 0), 1);
        if (err_q.size() != 0) chk("err_cycle", cyc, err_q.pop_front());
      end
      if (acc_clr) begin
        int e;
        chk("clr_expected", int'(clr_q.size() != 0), 1);
        if (clr_q.size() != 0) begin
          e = clr_q.pop_front();
          chk("clr_window", int'(cyc >= e && cyc <= e + 1), 1);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_smp_ready"}, int'(smp_ready), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_acc_start"}, int'(acc_start), 0);
    chk({tag, "_acc_xi"}, int'(acc_xi), 0);
    chk({tag, "_acc_xi2"}, int'(acc_xi2), 0);
    chk({tag, "_acc_yi"}, int'(acc_yi), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_beats_left"}, beat_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
    chk({tag, "_err_left"}, err_q.size(), 0);
    chk({tag, "_clr_left"}, clr_q.size(), 0);
  endtask

  // mode: 0 random, 1 ramp x=y=k, 2 x=7 with random y.
  // Accept edges are planned up front: sample k is accepted stall-free after
  // its gap, first possible acceptance being two edges after job_start.
  task automatic run_job(input int len, input int mode, input int maxgap,
                         input int stall_at, input int stall_len,
                         input bit ign, input int rst_after);
    int e, a, g, k, last_at;
    int at[$];
    int xs[$];
    int ys[$];
    @(negedge clk);
    job_start = 1'b1;
    job_len   = 8'(len);
    e = cyc + 1;
    clr_q.push_back(e);
    a = e + 1;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      g = (i == stall_at) ? stall_len : (maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      a = a + 1 + g;
      at.push_back(a);
      case (mode)
        1:       begin xs.push_back(i % 8); ys.push_back(i % 8); end
        2:       begin xs.push_back(7); ys.push_back(int'($urandom_range(0, 7))); end
        default: begin xs.push_back(int'($urandom_range(0, 7))); ys.push_back(int'($urandom_range(0, 7))); end
      endcase
      b.x = xs[i]; b.xi2 = xs[i] * xs[i]; b.y = ys[i]; b.at = a;
      if (rst_after < 0 || i < rst_after) beat_q.push_back(b);
    end
    last_at = a;
    if (rst_after < 0) done_q.push_back(last_at + ACC_LAT + 1);
    @(negedge clk);
    k = 0;
    while (k < len) begin
      job_start = ign && (cyc == e + 1);
      if (ign && cyc == e + 1) job_len = 8'd3;
      if (cyc + 1 == at[k]) begin
        smp_valid = 1'b1;
        smp_x = XW'(xs[k]);
        smp_y = YW'(ys[k]);
        k++;
      end else begin
        smp_valid = 1'b0;
      end
      @(negedge clk);
      if (rst_after >= 0 && k == rst_after) break;
    end
    smp_valid = 1'b0;
    job_start = 1'b0;
    if (rst_after >= 0) begin
      #2 rst_n = 1'b0;
      #1 chk_zero("midreset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_drained("midreset");
    end else begin
      while (cyc < last_at + ACC_LAT + 2) @(negedge clk);
      chk("post_job_busy", int'(busy), 0);
      chk_drained("job");
    end
  endtask

  task automatic zero_job();
    int e;
    @(negedge clk);
    job_start = 1'b1;
    job_len   = 8'd0;
    e = cyc + 1;
    err_q.push_back(e);
    @(negedge clk);
    job_start = 1'b0;
    chk("zero_len_busy0", int'(busy), 0);
    @(negedge clk);
    chk("zero_len_busy1", int'(busy), 0);
    chk_drained("zero_len");
  endtask

  initial begin
    #3 chk_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    zero_job();
    run_job(5, 1, 0, -1, 0, 1'b0, -1);     // nominal ramp, done 9 edges after start
    run_job(3, 1, 0, 2, 2, 1'b0, -1);      // 2-cycle stall before third sample
    run_job(5, 0, 0, -1, 0, 1'b1, -1);     // job_start during STREAM ignored
    run_job(4, 2, 1, -1, 0, 1'b0, -1);     // x=7 full-width square
    run_job(255, 0, 0, -1, 0, 1'b0, -1);   // maximum length
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 20)), 0, 3, -1, 0, 1'b0, -1);
    run_job(5, 1, 0, -1, 0, 1'b0, 2);      // reset after two beats
    run_job(5, 1, 0, -1, 0, 1'b0, -1);     // full pass after reset

`ifdef REGSEQ_TIMEOUT_EN
    begin
      int e;
      @(negedge clk);
      job_start = 1'b1;
      job_len   = 8'd3;
      e = cyc + 1;
      clr_q.push_back(e);
      err_q.push_back(e + 1 + TIMEOUT_CYC);
      @(negedge clk);
      job_start = 1'b0;
      while (cyc < e + TIMEOUT_CYC + 3) @(negedge clk);
      chk("timeout_busy", int'(busy), 0);
      chk_drained("timeout");
    end
`else
    run_job(2, 0, 0, 0, 20, 1'b0, -1);     // long stall: no timeout, job completes
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
